mmio_port_responder: RTL

Memory-mapped I/O responder on the processor's MEM-stage data bus; the target end of the load/store interface that the pipeline initiates.
- Decodes the I/O window and holds the output port register.
- Synchronises and edge-captures the 8-bit input port.
- Provides a compare timer with a sticky match flag.
- The top level steers ReadData into MEM_WB from this block when Hit=1, else from data RAM.

---
 rtl/mmio_pkg.sv | 35 +++
 rtl/mmio_sync_edge.sv | 40 ++++
 rtl/mmio_port_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// ============================================================================
// Module   : mmio_pkg
// Purpose  : Register offsets, STATUS bit indices and decode window for the
//            MMIO responder. MMIO_IRQ_EN widens the window to cover IRQ_MASK.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

   localparam logic [15:0] OFF_PORT_OUT  = 16'h0000;
   localparam logic [15:0] OFF_PORT_IN   = 16'h0004;
   localparam logic [15:0] OFF_IN_EDGE   = 16'h0008;
   localparam logic [15:0] OFF_TIMER_CNT = 16'h000C;
   localparam logic [15:0] OFF_TIMER_CMP = 16'h0010;
   localparam logic [15:0] OFF_STATUS    = 16'h0014;
   localparam logic [15:0] OFF_IRQ_MASK  = 16'h0018;

   localparam int STATUS_MATCH = 0;
   localparam int STATUS_TEN   = 1;

`ifdef MMIO_IRQ_EN
   localparam logic [15:0] WINDOW_SIZE = 16'h001C;
`else
   localparam logic [15:0] WINDOW_SIZE = 16'h0018;
`endif

   // Word index inside the window; byte lane bits are dropped.
   function automatic logic [2:0] wordIdx(input logic [15:0] off);
      return off[4:2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_sync_edge.sv
// ============================================================================
// Module   : mmio_sync_edge
// Purpose  : Two-flop synchroniser per input bit plus a "previous" flop that
//            yields a one-cycle rising-edge pulse vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pins,
   output logic [WIDTH-1:0] syncVal,
   output logic [WIDTH-1:0] risePulse
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= '0;
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_meta <= pins;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign syncVal   = r_sync;
   assign risePulse = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/mmio_port_responder.sv
// ============================================================================
// Module   : mmio_port_responder
// Purpose  : MEM-stage MMIO target: output port, synchronised input port with
//            sticky edge flags, compare timer. Optional IRQ: MMIO_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_port_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] IO_BASE       = 32'hFFFF_0000,
   parameter int          PORT_IN_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     MemRead,
   input  logic                     MemWrite,
   input  logic [31:0]              Address,
   input  logic [31:0]              WriteData,
   input  logic [PORT_IN_WIDTH-1:0] PortIn,
   output logic [31:0]              ReadData,
   output logic                     Hit,
   output logic [31:0]              PortOut,
   output logic                     irq
);

   logic [PORT_IN_WIDTH-1:0] w_syncVal;
   logic [PORT_IN_WIDTH-1:0] w_rise;

   logic [31:0]              r_portOut;
   logic [PORT_IN_WIDTH-1:0] r_inEdge;
   logic [31:0]              r_timerCnt;
   logic [31:0]              r_timerCmp;
   logic                     r_match;
   logic                     r_ten;

   logic       w_hit;
   logic       w_wrEn;
   logic [2:0] w_idx;
   logic       w_wrPortOut;
   logic       w_wrInEdge;
   logic       w_wrCnt;
   logic       w_wrCmp;
   logic       w_wrStatus;
   logic       w_matchEvt;
   logic [31:0] w_rdMux;

   wire w_unusedBits = &{1'b0, Address[1:0]};

   mmio_sync_edge #(
      .WIDTH (PORT_IN_WIDTH)
   ) u_syncEdge (
      .clk       (clk),
      .reset     (reset),
      .pins      (PortIn),
      .syncVal   (w_syncVal),
      .risePulse (w_rise)
   );

   assign w_hit  = (Address[31:16] == IO_BASE[31:16]) && (Address[15:0] < WINDOW_SIZE);
   assign w_wrEn = MemWrite && w_hit;
   assign w_idx  = Address[4:2];

   assign w_wrPortOut = w_wrEn && (w_idx == wordIdx(OFF_PORT_OUT));
   assign w_wrInEdge  = w_wrEn && (w_idx == wordIdx(OFF_IN_EDGE));
   assign w_wrCnt     = w_wrEn && (w_idx == wordIdx(OFF_TIMER_CNT));
   assign w_wrCmp     = w_wrEn && (w_idx == wordIdx(OFF_TIMER_CMP));
   assign w_wrStatus  = w_wrEn && (w_idx == wordIdx(OFF_STATUS));

   // A software load of TIMER_CNT suppresses both the reload and the MATCH set.
   assign w_matchEvt = r_ten && (r_timerCnt == r_timerCmp) && !w_wrCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_portOut  <= '0;
         r_inEdge   <= '0;
         r_timerCnt <= '0;
         r_timerCmp <= '0;
         r_match    <= 1'b0;
         r_ten      <= 1'b0;
      end else begin
         if (w_wrPortOut) r_portOut  <= WriteData;
         if (w_wrCmp)     r_timerCmp <= WriteData;
         if (w_wrStatus)  r_ten      <= WriteData[STATUS_TEN];

         // Set beats clear for both sticky flag groups.
         r_inEdge <= (r_inEdge & ~(w_wrInEdge ? WriteData[PORT_IN_WIDTH-1:0] : '0)) | w_rise;
         r_match  <= w_matchEvt | (r_match & ~(w_wrStatus & WriteData[STATUS_MATCH]));

         if (w_wrCnt) begin
            r_timerCnt <= WriteData;
         end else if (r_ten) begin
            r_timerCnt <= (r_timerCnt == r_timerCmp) ? 32'h0 : r_timerCnt + 32'h1;
         end
      end
   end

`ifdef MMIO_IRQ_EN
   // MATCH mask sits just above the IN_EDGE mask bits (bit 8 for an 8-bit port).
   logic [PORT_IN_WIDTH:0] r_irqMask;
   logic                   r_irq;
   logic                   w_wrIrqMask;

   assign w_wrIrqMask = w_wrEn && (w_idx == wordIdx(OFF_IRQ_MASK));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irqMask <= '0;
         r_irq     <= 1'b0;
      end else begin
         if (w_wrIrqMask) r_irqMask <= WriteData[PORT_IN_WIDTH:0];
         r_irq <= (|(r_inEdge & r_irqMask[PORT_IN_WIDTH-1:0]))
                | (r_match & r_irqMask[PORT_IN_WIDTH]);
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      w_rdMux = 32'h0;
      case (w_idx)
         wordIdx(OFF_PORT_OUT):  w_rdMux = r_portOut;
         wordIdx(OFF_PORT_IN):   w_rdMux = 32'(w_syncVal);
         wordIdx(OFF_IN_EDGE):   w_rdMux = 32'(r_inEdge);
         wordIdx(OFF_TIMER_CNT): w_rdMux = r_timerCnt;
         wordIdx(OFF_TIMER_CMP): w_rdMux = r_timerCmp;
         wordIdx(OFF_STATUS): begin
            w_rdMux[STATUS_MATCH] = r_match;
            w_rdMux[STATUS_TEN]   = r_ten;
         end
`ifdef MMIO_IRQ_EN
         wordIdx(OFF_IRQ_MASK):  w_rdMux = 32'(r_irqMask);
`endif
         default:                w_rdMux = 32'h0;
      endcase
   end

   assign ReadData = (MemRead && w_hit) ? w_rdMux : 32'h0;
   assign Hit      = w_hit;
   assign PortOut  = r_portOut;

endmodule

`default_nettype wire
